pipelined_memory: RTL

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

---
 rtl/pipelined_memory.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipelined_memory.sv
// Byte-strobed memory with a fixed-latency response pipeline feeding an
// elastic response FIFO; requests are throttled by the count of unretired responses.
module pipelined_memory #(
   parameter int unsigned       AWIDTH      = 32,
   parameter int unsigned       DWIDTH      = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h01000000,
   parameter int unsigned       DEPTH_BYTES = 4096,
   parameter int unsigned       RD_LATENCY  = 2,
   parameter string             INIT_FILE   = ""
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [AWIDTH-1:0]   req_addr_i,
   input  logic [DWIDTH-1:0]   req_data_i,
   input  logic [DWIDTH/8-1:0] req_strb_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DWIDTH-1:0]   rsp_data_o,
   output logic                rsp_err_o,
   output logic                rsp_write_o,
   output logic [15:0]         err_count_o,
   output logic [2:0]          outstanding_o
);

   localparam int unsigned NB          = DWIDTH / 8;
   localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / NB;
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
   localparam int unsigned OFF_LSB     = $clog2(NB);
   localparam int unsigned FIFO_DEPTH  = RD_LATENCY + 1;
   localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic              write;
      logic              err;
      logic [DWIDTH-1:0] data;
   } rsp_t;

   logic [DWIDTH-1:0] mem [DEPTH_WORDS];

   logic [AWIDTH-1:0] offset_c;
   logic [IDX_W-1:0]  idx_c;
   logic              addr_known_c;
   logic              in_range_c;
   logic              accept_c;
   logic              retire_c;
   logic [2:0]        outstanding_next_c;
   rsp_t              new_c;
   rsp_t              fifo_in_c;

   rsp_t              fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifndef SYNTHESIS
   assign addr_known_c = !$isunknown(req_addr_i);
`else
   assign addr_known_c = 1'b1;
`endif

   // Address decode: the access uses the offset aligned down to a whole word.
   assign offset_c   = req_addr_i - BASE_ADDR;
   assign in_range_c = addr_known_c && (req_addr_i >= BASE_ADDR) &&
                       (offset_c <= AWIDTH'(DEPTH_BYTES - NB));
   assign idx_c      = IDX_W'(offset_c >> OFF_LSB);
   assign accept_c   = req_valid_i && req_ready_o;
   assign retire_c   = rsp_valid_o && rsp_ready_i;

   // Power-on contents; reset never touches the array.
   initial begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] = '0;
   end

   always_ff @(posedge clk) begin
      if (accept_c && req_write_i && in_range_c) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (req_strb_i[b]) mem[idx_c][b*8 +: 8] <= req_data_i[b*8 +: 8];
         end
      end
   end

   // Response entry formed from the pre-write memory contents at the accepting edge.
   always_comb begin
      new_c       = '0;
      new_c.valid = accept_c;
      new_c.write = req_write_i;
      new_c.err   = !in_range_c;
      if (!req_write_i && in_range_c) new_c.data = mem[idx_c];
   end

   // RD_LATENCY-1 shift stages; the FIFO write forms the final stage.
   generate
      if (RD_LATENCY == 1) begin : g_direct
         assign fifo_in_c = new_c;
      end else begin : g_pipe
         rsp_t pipe_q [RD_LATENCY-1];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < int'(RD_LATENCY) - 1; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= new_c;
               for (int i = 1; i < int'(RD_LATENCY) - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign fifo_in_c = pipe_q[RD_LATENCY-2];
      end
   endgenerate

   assign outstanding_next_c = outstanding_o + 3'(accept_c) - 3'(retire_c);

   // Output FIFO, outstanding tracking and error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_o <= '0;
         req_ready_o   <= 1'b0;
         err_count_o   <= '0;
      end else begin
         if (fifo_in_c.valid) begin
            fifo_q[wr_ptr_q] <= fifo_in_c;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (retire_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q       <= count_q + CNT_W'(fifo_in_c.valid) - CNT_W'(retire_c);
         outstanding_o <= outstanding_next_c;
         req_ready_o   <= (outstanding_next_c < 3'(RD_LATENCY + 1));
         if (retire_c && fifo_q[rd_ptr_q].err && (err_count_o != 16'hFFFF)) begin
            err_count_o <= err_count_o + 16'd1;
         end
      end
   end

   assign rsp_valid_o = (count_q != '0) && fifo_q[rd_ptr_q].valid;
   assign rsp_data_o  = rsp_valid_o ? fifo_q[rd_ptr_q].data : '0;
   assign rsp_err_o   = rsp_valid_o && fifo_q[rd_ptr_q].err;
   assign rsp_write_o = rsp_valid_o && fifo_q[rd_ptr_q].write;

endmodule
